dmem_miss_sequencer: RTL and testbench

Sequences the MEM-stage data memory on a miss. It detects a load that misses, freezes the MEM/WB pipeline register, and fetches the missing line from backing memory through a request/acknowledge plus beat-valid handshake. It then replays the access and releases the pipeline. It sits beside the MEM stage: it drives the MEM/WB register's write enable and the data memory's fill port, and it counts misses for performance monitoring.

---
 rtl/dmem_miss_sequencer_pkg.sv | 26 ++
 rtl/dmem_beat_counter.sv | 37 +++
 rtl/dmem_miss_sequencer.sv | 144 ++++++++++++++
 tb/tb_dmem_miss_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_miss_sequencer_pkg.sv
// Shared definitions for the MEM-stage data-memory miss sequencer.
//   - seqState_e         : sequencer FSM states
//   - LineBytesDefault   : default data-memory line size in bytes
//   - RefillBeatsDefault : default number of 32-bit beats per line refill
//   - lineAlign()        : clears the byte-in-line bits of an address
package dmem_miss_sequencer_pkg;

    localparam int unsigned LineBytesDefault   = 16;
    localparam int unsigned RefillBeatsDefault = LineBytesDefault / 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFill,
        StReplay
    } seqState_e;

    // lineBytes must be a power of two.
    function automatic logic [31:0] lineAlign(input logic [31:0] addr,
                                              input int unsigned lineBytes);
        logic [31:0] mask;
        mask = ~(lineBytes - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/dmem_beat_counter.sv
// Refill beat counter.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   clear_i    : synchronous clear (has priority over enable_i)
//   enable_i   : advance the count by one
//   count_o    : current beat index
//   terminal_o : count_o equals the last beat index (REFILL_BEATS-1)
module dmem_beat_counter #(
    parameter int unsigned BEAT_W       = 2,
    parameter int unsigned REFILL_BEATS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    output logic [BEAT_W-1:0] count_o,
    output logic              terminal_o
);

    localparam logic [BEAT_W-1:0] TermCount = BEAT_W'(REFILL_BEATS - 1);

    logic [BEAT_W-1:0] countQ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            countQ <= '0;
        end else if (clear_i) begin
            countQ <= '0;
        end else if (enable_i) begin
            countQ <= countQ + 1'b1;
        end
    end

    assign count_o    = countQ;
    assign terminal_o = (countQ == TermCount);

endmodule

// File: rtl/dmem_miss_sequencer.sv
// MEM-stage data-memory miss sequencer. Detects a load miss, stalls the MEM/WB
// register, refills the line from backing memory and replays the access.
//   clk                  : pipeline clock
//   reset                : asynchronous active-low reset
//   mem_req              : MEM stage holds a valid load
//   mem_address          : byte address of the MEM-stage access
//   mem_hit              : same-cycle hit indication from the data memory
//   p4_pipeline_regWrite : MEM/WB write enable (0 = stall)
//   refill_req           : line refill request to backing memory
//   refill_addr          : line-aligned refill address
//   refill_ack           : backing memory accepted the request
//   refill_valid         : one refill beat present this cycle
//   fill_we / fill_beat  : data-memory fill write, one cycle after the beat
//   miss_count           : saturating miss counter
module dmem_miss_sequencer
    import dmem_miss_sequencer_pkg::*;
#(
    parameter int unsigned LINE_BYTES      = LineBytesDefault,
    parameter int unsigned REFILL_BEATS    = RefillBeatsDefault,
    parameter int unsigned BEAT_W          = 2,
    // Reset value of miss_count; nonzero only to preload the counter near saturation.
    parameter logic [15:0] MISS_COUNT_INIT = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic [31:0]       mem_address,
    input  logic              mem_hit,
    output logic              p4_pipeline_regWrite,
    output logic              refill_req,
    output logic [31:0]       refill_addr,
    input  logic              refill_ack,
    input  logic              refill_valid,
    output logic              fill_we,
    output logic [BEAT_W-1:0] fill_beat,
    output logic [15:0]       miss_count
);

    seqState_e         stateQ, stateD;
    logic [31:0]       refillAddrQ, refillAddrD;
    logic [15:0]       missCountQ, missCountD;
    logic              fillWeQ;
    logic [BEAT_W-1:0] fillBeatQ;

    logic              stall;
    logic              missNow;
    logic              cntClear;
    logic              cntEnable;
    logic              cntTerminal;
    logic [BEAT_W-1:0] cntValue;

    dmem_beat_counter #(
        .BEAT_W       (BEAT_W),
        .REFILL_BEATS (REFILL_BEATS)
    ) uBeatCounter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (cntClear),
        .enable_i   (cntEnable),
        .count_o    (cntValue),
        .terminal_o (cntTerminal)
    );

    always_comb begin
        stateD      = stateQ;
        refillAddrD = refillAddrQ;
        missCountD  = missCountQ;
        cntClear    = 1'b0;
        cntEnable   = 1'b0;
        missNow     = 1'b0;
        stall       = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (mem_req && !mem_hit) begin
                    missNow = 1'b1;
                    stateD  = StReq;
                end
            end
            StReq: begin
                stall = 1'b1;
                if (refill_ack) begin
                    cntClear = 1'b1;
                    stateD   = StFill;
                end
            end
            StFill: begin
                stall = 1'b1;
                if (refill_valid) begin
                    cntEnable = 1'b1;
                    if (cntTerminal) begin
                        stateD = StReplay;
                    end
                end
            end
            StReplay: begin
                // A flush or a hit releases the pipeline; the hit wins over a new request.
                if (!mem_req || mem_hit) begin
                    stateD = StIdle;
                end else begin
                    missNow = 1'b1;
                    stateD  = StReq;
                end
            end
            default: stateD = StIdle;
        endcase

        // Stall in the detect cycle too, so MEM/WB never captures missed data.
        if (missNow) begin
            stall       = 1'b1;
            refillAddrD = lineAlign(mem_address, LINE_BYTES);
            if (missCountQ != 16'hFFFF) begin
                missCountD = missCountQ + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ      <= StIdle;
            refillAddrQ <= '0;
            missCountQ  <= MISS_COUNT_INIT;
            fillWeQ     <= 1'b0;
            fillBeatQ   <= '0;
        end else begin
            stateQ      <= stateD;
            refillAddrQ <= refillAddrD;
            missCountQ  <= missCountD;
            fillWeQ     <= (stateQ == StFill) && refill_valid;
            if ((stateQ == StFill) && refill_valid) begin
                fillBeatQ <= cntValue;
            end
        end
    end

    // The request is a decode of the registered state, so it is glitch-free.
    assign refill_req           = (stateQ == StReq);
    assign refill_addr          = refillAddrQ;
    assign fill_we              = fillWeQ;
    assign fill_beat            = fillBeatQ;
    assign miss_count           = missCountQ;
    assign p4_pipeline_regWrite = ~stall;

endmodule

// File: tb/tb_dmem_miss_sequencer.sv
// Self-checking bench for dmem_miss_sequencer. Expected refill addresses and fill
// beats are queued as stimulus is driven and compared as the DUT produces them.
module tb_dmem_miss_sequencer;

    localparam int unsigned LineBytes   = 16;
    localparam int unsigned RefillBeats = 4;
    localparam int unsigned BeatW       = 2;

    logic clk = 1'b0;
    logic reset;
    logic mem_req;
    logic [31:0] mem_address;
    logic mem_hit;
    logic refill_ack;
    logic refill_valid;

    logic             p4;
    logic             refill_req;
    logic [31:0]      refill_addr;
    logic             fill_we;
    logic [BeatW-1:0] fill_beat;
    logic [15:0]      miss_count;

    logic             satP4;
    logic             satReq;
    logic [31:0]      satAddr;
    logic             satWe;
    logic [BeatW-1:0] satBeat;
    logic [15:0]      satCount;

    always #5 clk = ~clk;

    dmem_miss_sequencer #(
        .LINE_BYTES   (LineBytes),
        .REFILL_BEATS (RefillBeats),
        .BEAT_W       (BeatW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .mem_req              (mem_req),
        .mem_address          (mem_address),
        .mem_hit              (mem_hit),
        .p4_pipeline_regWrite (p4),
        .refill_req           (refill_req),
        .refill_addr          (refill_addr),
        .refill_ack           (refill_ack),
        .refill_valid         (refill_valid),
        .fill_we              (fill_we),
        .fill_beat            (fill_beat),
        .miss_count           (miss_count)
    );

    // Same stimulus, miss counter preloaded to 16'hFFFE.
    dmem_miss_sequencer #(
        .LINE_BYTES      (LineBytes),
        .REFILL_BEATS    (RefillBeats),
        .BEAT_W          (BeatW),
        .MISS_COUNT_INIT (16'hFFFE)
    ) dutSat (
        .clk                  (clk),
        .reset                (reset),
        .mem_req              (mem_req),
        .mem_address          (mem_address),
        .mem_hit              (mem_hit),
        .p4_pipeline_regWrite (satP4),
        .refill_req           (satReq),
        .refill_addr          (satAddr),
        .refill_ack           (refill_ack),
        .refill_valid         (refill_valid),
        .fill_we              (satWe),
        .fill_beat            (satBeat),
        .miss_count           (satCount)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] addrQ[$];
    int          beatQ[$];
    int          stallCnt;
    int          reqCnt;
    int          fillCnt;
    logic        reqPrev;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-cycle scoreboard work, called at the falling edge.
    task automatic observe();
        if (fill_we) begin
            fillCnt++;
            if (beatQ.size() == 0) checkEq("fill_we without a beat", 32'(fill_we), 32'd0);
            else                   checkEq("fill_beat", 32'(fill_beat), 32'(beatQ.pop_front()));
        end
        if (refill_req) begin
            reqCnt++;
            if (!reqPrev) begin
                if (addrQ.size() == 0) checkEq("refill_req without a miss", 32'(refill_req), 32'd0);
                else                   checkEq("refill_addr", refill_addr, addrQ.pop_front());
            end
        end
        reqPrev = refill_req;
        if (!p4) stallCnt++;
    endtask

    task automatic sample();
        @(negedge clk);
        observe();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    // One miss: detect, REQ (ack after ackDelay cycles), FILL (optional gap after beat 1),
    // REPLAY; replayMisses extra REPLAY misses re-run REQ/FILL before the final hit.
    task automatic missTxn(input logic [31:0] addr, input logic [31:0] expAddr,
                           input int ackDelay, input int gapLen, input int replayMisses,
                           input int expPenalty, input int expReqCycles,
                           input logic [15:0] expMiss);
        stallCnt     = 0;
        reqCnt       = 0;
        fillCnt      = 0;
        mem_req      = 1'b1;
        mem_address  = addr;
        mem_hit      = 1'b0;
        refill_ack   = 1'b0;
        refill_valid = 1'b0;
        addrQ.push_back(expAddr);
        tick();
        for (int r = 0; r <= replayMisses; r++) begin
            for (int d = 0; d < ackDelay; d++) begin
                refill_valid = 1'b1;   // must be ignored while waiting for ack
                tick();
            end
            refill_valid = 1'b0;
            refill_ack   = 1'b1;
            tick();
            refill_ack = 1'b0;
            for (int b = 0; b < int'(RefillBeats); b++) begin
                refill_valid = 1'b1;
                beatQ.push_back(b);
                tick();
                if (b == 1) begin
                    for (int g = 0; g < gapLen; g++) begin
                        refill_valid = 1'b0;
                        tick();
                    end
                end
            end
            refill_valid = 1'b0;
            if (r < replayMisses) begin
                mem_hit = 1'b0;
                addrQ.push_back(expAddr);
                tick();
            end else begin
                mem_hit = 1'b1;
                sample();
                checkEq("MEM/WB writes in replay", 32'(p4), 32'd1);
                advance();
            end
        end
        // Penalty = stalled cycles plus the replay cycle that writes MEM/WB.
        checkEq("miss penalty", 32'(stallCnt + 1), 32'(expPenalty));
        checkEq("refill_req cycles", 32'(reqCnt), 32'(expReqCycles));
        checkEq("fill_we count", 32'(fillCnt), 32'(int'(RefillBeats) * (replayMisses + 1)));
        checkEq("refill addr drained", 32'(addrQ.size()), 32'd0);
        checkEq("fill beats drained", 32'(beatQ.size()), 32'd0);
        checkEq("miss_count", 32'(miss_count), 32'(expMiss));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        mem_req      = 1'b0;
        mem_address  = 32'h0;
        mem_hit      = 1'b0;
        refill_ack   = 1'b0;
        refill_valid = 1'b0;
        reqPrev      = 1'b0;
        stallCnt     = 0;
        reqCnt       = 0;
        fillCnt      = 0;
        repeat (2) advance();

        // Reset values
        sample();
        checkEq("reset refill_req", 32'(refill_req), 32'd0);
        checkEq("reset refill_addr", refill_addr, 32'd0);
        checkEq("reset fill_we", 32'(fill_we), 32'd0);
        checkEq("reset fill_beat", 32'(fill_beat), 32'd0);
        checkEq("reset miss_count", 32'(miss_count), 32'd0);
        checkEq("reset regWrite", 32'(p4), 32'd1);
        advance();
        reset = 1'b1;
        tick();

        // Hit path
        for (int i = 0; i < 10; i++) begin
            mem_req     = 1'b1;
            mem_hit     = 1'b1;
            mem_address = 32'h100 + 32'(i * 4);
            sample();
            checkEq("hit regWrite", 32'(p4), 32'd1);
            checkEq("hit refill_req", 32'(refill_req), 32'd0);
            advance();
        end
        checkEq("hit miss_count", 32'(miss_count), 32'd0);

        // Single miss: 1 + 1 + 4 stalled, replay writes -> 7-cycle penalty
        missTxn(32'h0000_1234, 32'h0000_1230, 0, 0, 0, 7, 1, 16'd1);
        // Slow memory: 1 + 6 + 6 stalled + replay = 14
        missTxn(32'hDEAD_BEEF, 32'hDEAD_BEE0, 5, 2, 0, 14, 6, 16'd2);
        // Replay miss: 1 + (1+4+1) + (1+4) stalled + replay = 13, continuous stall
        missTxn(32'h8000_000C, 32'h8000_0000, 0, 0, 1, 13, 2, 16'd4);

        // Reset mid-FILL, right after beat 1
        mem_req     = 1'b1;
        mem_hit     = 1'b0;
        mem_address = 32'h0000_2008;
        addrQ.push_back(32'h0000_2000);
        tick();
        refill_ack = 1'b1;
        tick();
        refill_ack   = 1'b0;
        refill_valid = 1'b1;
        beatQ.push_back(0);
        tick();
        beatQ.push_back(1);
        tick();
        refill_valid = 1'b0;
        mem_req      = 1'b0;
        reset        = 1'b0;
        beatQ.delete();
        sample();
        checkEq("mid-fill reset refill_req", 32'(refill_req), 32'd0);
        checkEq("mid-fill reset fill_we", 32'(fill_we), 32'd0);
        checkEq("mid-fill reset miss_count", 32'(miss_count), 32'd0);
        checkEq("mid-fill reset refill_addr", refill_addr, 32'd0);
        checkEq("mid-fill reset preloaded count", 32'(satCount), 32'h0000_FFFE);
        advance();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_req     = 1'b1;
            mem_hit     = 1'b1;
            mem_address = 32'h0000_3000;
            sample();
            checkEq("post-reset hit regWrite", 32'(p4), 32'd1);
            advance();
        end

        // Back-to-back misses; preloaded instance saturates
        missTxn(32'h0000_0040, 32'h0000_0040, 0, 0, 0, 7, 1, 16'd1);
        checkEq("saturating count 1", 32'(satCount), 32'h0000_FFFF);
        missTxn(32'h0000_007F, 32'h0000_0070, 0, 0, 0, 7, 1, 16'd2);
        checkEq("saturating count 2", 32'(satCount), 32'h0000_FFFF);
        missTxn(32'h0000_0100, 32'h0000_0100, 0, 0, 0, 7, 1, 16'd3);
        checkEq("saturating count 3", 32'(satCount), 32'h0000_FFFF);

        mem_req = 1'b0;
        mem_hit = 1'b0;
        repeat (3) tick();
        checkEq("idle refill_req", 32'(refill_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
